mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  RV32I MEM stage directly downstream of the execute unit: EX/MEM pipeline register,
//  load/store alignment, and a req/ack data-memory handshake with a stall FSM.
//  Its mem_ALU_out is the operand the execute unit's forwarding muxes take on select 2.
//  Feeds the writeback mux (load data, ALU result, PC+4).
// PARAMETERS
//  TIMEOUT  16  max cycles BUSY waits for dmem_ack before bus error; 0 = never time out
// PORTS
//  clk            in   1   clock; all state updates on rising edge
//  rst_n          in   1   reset, synchronous, active-low
//  ex_valid       in   1   EX slot holds a real instruction (0 = bubble)
//  ex_ALU_out     in   32  ALU result / effective address
//  ex_DataB       in   32  forwarded rs2, store data
//  ex_pc4         in   32  PC+4 for JAL/JALR writeback
//  ex_rd          in   5   destination register
//  ex_RegWEn      in   1   register write enable
//  ex_MemEn       in   1   instruction is load/store
//  ex_MemRW       in   1   1 = store, 0 = load
//  ex_funct3      in   3   access size / sign
//  ex_WBSel       in   2   writeback select (passed through)
//  dmem_ack       in   1   memory completes the request this cycle
//  dmem_rdata     in   32  read word, valid with dmem_ack
//  mem_valid      out  1   MEM register holds a real instruction
//  mem_ALU_out    out  32  registered ALU result (forwarding + WB)
//  mem_pc4        out  32  registered PC+4
//  mem_rd         out  5   registered rd
//  mem_RegWEn     out  1   registered RegWEn, forced 0 on fault
//  mem_WBSel      out  2   registered WBSel
//  mem_load_data  out  32  aligned, extended load result
//  mem_stall      out  1   MEM busy; upstream and this register must hold
//  mem_fault      out  1   misaligned address or illegal funct3
//  mem_bus_err    out  1   dmem timeout on this instruction
//  dmem_req       out  1   request valid
//  dmem_we        out  1   write request
//  dmem_addr      out  32  word address {mem_ALU_out[31:2],2'b00}
//  dmem_wdata     out  32  lane-replicated store data
//  dmem_be        out  4   byte enables
// BEHAVIOUR
//  Reset, sync: rst_n=0 at an edge zeroes every register and output. State goes IDLE,
//   dmem_req=0 from the next cycle. An outstanding ack is then ignored; reset mid-BUSY aborts the access.
//  MEM register: captures all ex_* when mem_stall=0, holds when mem_stall=1.
//  FSM IDLE/BUSY, next state decoded from ex_* at the capture edge:
//   ex_valid & ex_MemEn & aligned & legal -> BUSY; otherwise IDLE.
//   BUSY: dmem_req=1; mem_stall=1; addr/we/be/wdata held stable from the MEM register.
//   Ack in BUSY, incl. the first BUSY cycle: register mem_load_data, go IDLE.
//   Next cycle: mem_stall=0, load data valid, register advances on the following edge.
//   Timing: zero-wait memory = 2 cycles in MEM; k wait cycles = k+2; non-memory op = 1.
//  Timeout: counter clears on BUSY entry and increments each BUSY cycle without ack.
//   At count==TIMEOUT-1 without ack: go IDLE, set mem_bus_err=1, force mem_RegWEn=0.
//  Ack in IDLE is ignored. dmem_req=0 in IDLE.
//  Size, funct3 (addr = ALU_out[1:0]):
//   000 LB/SB, 100 LBU: any addr.
//   001 LH/SH, 101 LHU: addr[0]=0.
//   010 LW/SW: addr=00.
//   011/110/111 illegal.
//   Violation -> mem_fault=1, no request, mem_RegWEn=0, 1-cycle occupancy.
//   Stores: loads only for LBU/LHU codes.
//  Store be/wdata:
//   SB be=4'b0001<<addr, wdata={4{b}}.
//   SH be=4'b0011<<{addr[1],1'b0}, wdata={2{h}}.
//   SW be=4'hF.
//  Load: select byte/half by addr; LB/LH sign-extend, LBU/LHU zero-extend.
//   mem_load_data=0 for non-loads.
//  Fault flags are registered with the instruction and clear when a new instruction is captured.
//  Bubble (ex_valid=0): captured with mem_valid=0, RegWEn=0, no request.
// STRUCTURE
//  Parameter.v: funct3 size codes, WBSel encodings, FSM state encodings.
//  Sub-module load_store_align, combinational: funct3 + addr[1:0] + store data + rdata
//   -> be, wdata, load_data, misaligned/illegal flag.
//  FSM, timeout counter and pipeline register stay in mem_access_stage.
// TESTING
//  ALU op, ex_ALU_out=0x1234, rd=5 -> next cycle mem_ALU_out=0x1234, mem_rd=5, no dmem_req.
//  SB addr 0x103, DataB=0xAB, ack same cycle -> be=1000, wdata=ABABABAB, stall for 1 cycle.
//  LB addr 0x102, rdata=0x0080_0000, ack after 3 waits -> stall 4 cycles, load=0xFFFFFF80.
//   Same access as LBU -> load=0x00000080.
//  LW addr 0x102 -> mem_fault=1, dmem_req never asserted, mem_RegWEn=0.
//  TIMEOUT=16, no ack -> BUSY 16 cycles, then mem_bus_err=1, mem_stall=0.
//  rst_n=0 during BUSY -> next cycle dmem_req=0, all outputs 0; later ack has no effect.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage_pkg
// Purpose  : Shared encodings for the RV32I MEM stage: funct3 access-size
//            codes, writeback-select encodings, MEM FSM state type and a
//            funct3 legality helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_access_stage_pkg;

  // funct3 access-size / sign codes
  localparam logic [2:0] c_F3_B  = 3'b000;
  localparam logic [2:0] c_F3_H  = 3'b001;
  localparam logic [2:0] c_F3_W  = 3'b010;
  localparam logic [2:0] c_F3_BU = 3'b100;
  localparam logic [2:0] c_F3_HU = 3'b101;

  // Writeback select encodings (passed through this stage)
  localparam logic [1:0] c_WB_MEM = 2'd0;
  localparam logic [1:0] c_WB_ALU = 2'd1;
  localparam logic [1:0] c_WB_PC4 = 2'd2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_t;

  // Unsigned-size codes exist only for loads; stores accept B/H/W only.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    logic ok;
    ok = 1'b0;
    case (f3)
      c_F3_B, c_F3_H, c_F3_W: ok = 1'b1;
      c_F3_BU, c_F3_HU:       ok = ~is_store;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_stage_load_store_align.sv
`default_nettype none
// ============================================================================
// Module   : load_store_align
// Purpose  : Combinational load/store lane alignment for the MEM stage.
// Ports    : i_funct3    access size/sign code
//            i_addr      byte offset within the word
//            i_is_store  1 = store, 0 = load
//            i_sdata     store data (rs2)
//            i_rdata     read word from data memory
//            o_be        byte enables
//            o_wdata     lane-replicated store data
//            o_load_data selected and extended load result
//            o_bad       misaligned address or illegal funct3
// Revision : 1.0 - initial release
// ============================================================================
module load_store_align
  import mem_access_stage_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr,
  input  logic        i_is_store,
  input  logic [31:0] i_sdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data,
  output logic        o_bad
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_misaligned;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_be         = 4'b0000;
    o_wdata      = i_sdata;
    o_load_data  = 32'h0;
    w_misaligned = 1'b0;
    case (i_funct3)
      c_F3_B, c_F3_BU: begin
        o_be        = 4'b0001 << i_addr;
        o_wdata     = {4{i_sdata[7:0]}};
        o_load_data = (i_funct3 == c_F3_B) ? {{24{w_byte[7]}}, w_byte}
                                           : {24'h0, w_byte};
      end
      c_F3_H, c_F3_HU: begin
        o_be         = 4'b0011 << {i_addr[1], 1'b0};
        o_wdata      = {2{i_sdata[15:0]}};
        o_load_data  = (i_funct3 == c_F3_H) ? {{16{w_half[15]}}, w_half}
                                            : {16'h0, w_half};
        w_misaligned = i_addr[0];
      end
      c_F3_W: begin
        o_be         = 4'hF;
        o_load_data  = i_rdata;
        w_misaligned = (i_addr != 2'b00);
      end
      default: begin
        o_be = 4'b0000;
      end
    endcase
    o_bad = w_misaligned | ~f3_legal(i_funct3, i_is_store);
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : RV32I MEM stage: EX/MEM pipeline register, load/store alignment
//            and a req/ack data-memory handshake with a stall FSM and timeout.
// Ports    : clk, rst_n (sync, active-low)
//            ex_*        instruction fields from the execute unit
//            dmem_ack/dmem_rdata   memory response
//            mem_*       registered stage outputs, stall and fault flags
//            dmem_*      memory request (req/we/addr/wdata/be)
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_ALU_out,
  input  logic [31:0] ex_DataB,
  input  logic [31:0] ex_pc4,
  input  logic [4:0]  ex_rd,
  input  logic        ex_RegWEn,
  input  logic        ex_MemEn,
  input  logic        ex_MemRW,
  input  logic [2:0]  ex_funct3,
  input  logic [1:0]  ex_WBSel,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_valid,
  output logic [31:0] mem_ALU_out,
  output logic [31:0] mem_pc4,
  output logic [4:0]  mem_rd,
  output logic        mem_RegWEn,
  output logic [1:0]  mem_WBSel,
  output logic [31:0] mem_load_data,
  output logic        mem_stall,
  output logic        mem_fault,
  output logic        mem_bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be
);

  localparam int                 c_CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

  mem_state_t         r_state, w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic               w_timeout;
  logic               w_busy;

  logic        r_valid, r_regwen, r_we, r_fault, r_bus_err;
  logic [31:0] r_alu, r_pc4, r_wdata, r_load;
  logic [4:0]  r_rd;
  logic [2:0]  r_funct3;
  logic [1:0]  r_wbsel;
  logic [3:0]  r_be;

  logic [2:0]  w_al_f3;
  logic [1:0]  w_al_addr;
  logic        w_al_store;
  logic [3:0]  w_al_be;
  logic [31:0] w_al_wdata, w_al_load;
  logic        w_al_bad;

  assign w_busy = (r_state == ST_BUSY);

  // One aligner serves both phases: in IDLE it checks the incoming EX
  // instruction (fault, be, wdata are captured), in BUSY it decodes the held
  // access so the returning read word can be aligned.
  assign w_al_f3    = w_busy ? r_funct3   : ex_funct3;
  assign w_al_addr  = w_busy ? r_alu[1:0] : ex_ALU_out[1:0];
  assign w_al_store = w_busy ? r_we       : ex_MemRW;

  load_store_align u_align (
    .i_funct3    (w_al_f3),
    .i_addr      (w_al_addr),
    .i_is_store  (w_al_store),
    .i_sdata     (ex_DataB),
    .i_rdata     (dmem_rdata),
    .o_be        (w_al_be),
    .o_wdata     (w_al_wdata),
    .o_load_data (w_al_load),
    .o_bad       (w_al_bad)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // IDLE is exactly when the register captures, so decode from ex_*.
        if (ex_valid && ex_MemEn && !w_al_bad) w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (dmem_ack) begin
          w_state_nxt = ST_IDLE;
        end else if ((TIMEOUT != 0) && (r_cnt == c_CNT_LAST)) begin
          w_state_nxt = ST_IDLE;
          w_timeout   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !w_busy) r_cnt <= '0;
    else if (!dmem_ack)    r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_alu     <= '0;
      r_pc4     <= '0;
      r_rd      <= '0;
      r_regwen  <= 1'b0;
      r_we      <= 1'b0;
      r_funct3  <= '0;
      r_wbsel   <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_load    <= '0;
      r_fault   <= 1'b0;
      r_bus_err <= 1'b0;
    end else if (!w_busy) begin
      r_valid   <= ex_valid;
      r_alu     <= ex_ALU_out;
      r_pc4     <= ex_pc4;
      r_rd      <= ex_rd;
      r_regwen  <= ex_valid & ex_RegWEn & ~(ex_MemEn & w_al_bad);
      r_we      <= ex_MemRW;
      r_funct3  <= ex_funct3;
      r_wbsel   <= ex_WBSel;
      r_be      <= w_al_be;
      r_wdata   <= w_al_wdata;
      r_load    <= '0;
      r_fault   <= ex_valid & ex_MemEn & w_al_bad;
      r_bus_err <= 1'b0;
    end else if (dmem_ack) begin
      r_load <= r_we ? 32'h0 : w_al_load;
    end else if (w_timeout) begin
      r_bus_err <= 1'b1;
      r_regwen  <= 1'b0;
    end
  end

  assign mem_valid     = r_valid;
  assign mem_ALU_out   = r_alu;
  assign mem_pc4       = r_pc4;
  assign mem_rd        = r_rd;
  assign mem_RegWEn    = r_regwen;
  assign mem_WBSel     = r_wbsel;
  assign mem_load_data = r_load;
  assign mem_stall     = w_busy;
  assign mem_fault     = r_fault;
  assign mem_bus_err   = r_bus_err;

  // Request-side outputs are quiet outside BUSY.
  assign dmem_req   = w_busy;
  assign dmem_we    = w_busy & r_we;
  assign dmem_addr  = {r_alu[31:2], 2'b00};
  assign dmem_wdata = w_busy ? r_wdata : 32'h0;
  assign dmem_be    = w_busy ? r_be : 4'h0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Purpose  : Directed self-checking bench for mem_access_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

  logic        clk, rst_n;
  logic        ex_valid, ex_RegWEn, ex_MemEn, ex_MemRW, dmem_ack;
  logic [31:0] ex_ALU_out, ex_DataB, ex_pc4, dmem_rdata;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_WBSel;
  logic        mem_valid, mem_RegWEn, mem_stall, mem_fault, mem_bus_err;
  logic        dmem_req, dmem_we;
  logic [31:0] mem_ALU_out, mem_pc4, mem_load_data, dmem_addr, dmem_wdata;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_WBSel;
  logic [3:0]  dmem_be;

  int checks   = 0;
  int failures = 0;

  mem_access_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ALU_out(ex_ALU_out), .ex_DataB(ex_DataB),
    .ex_pc4(ex_pc4), .ex_rd(ex_rd), .ex_RegWEn(ex_RegWEn), .ex_MemEn(ex_MemEn),
    .ex_MemRW(ex_MemRW), .ex_funct3(ex_funct3), .ex_WBSel(ex_WBSel),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_valid(mem_valid), .mem_ALU_out(mem_ALU_out), .mem_pc4(mem_pc4),
    .mem_rd(mem_rd), .mem_RegWEn(mem_RegWEn), .mem_WBSel(mem_WBSel),
    .mem_load_data(mem_load_data), .mem_stall(mem_stall), .mem_fault(mem_fault),
    .mem_bus_err(mem_bus_err), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [31:0] alu, input logic [31:0] db,
                        input logic [4:0] rd, input logic we_reg, input logic men,
                        input logic mrw, input logic [2:0] f3);
    ex_valid   = v;
    ex_ALU_out = alu;
    ex_DataB   = db;
    ex_pc4     = alu + 32'd4;
    ex_rd      = rd;
    ex_RegWEn  = we_reg;
    ex_MemEn   = men;
    ex_MemRW   = mrw;
    ex_funct3  = f3;
    ex_WBSel   = men ? 2'd0 : 2'd1;
  endtask

  task automatic set_bubble();
    set_ex(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    set_ex(1'b1, 32'hDEAD_BEEC, 32'h1111_2222, 5'd9, 1'b1, 1'b1, 1'b1, 3'b010);
    clk_step(); clk_step();
    checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", mem_valid); end
    checks++; if (mem_ALU_out !== 32'h0) begin failures++; $display("FAIL reset_alu got=%h exp=0", mem_ALU_out); end
    checks++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin failures++; $display("FAIL reset_req got=%b%b exp=00", dmem_req, mem_stall); end
    checks++; if (dmem_be !== 4'h0 || dmem_wdata !== 32'h0) begin failures++; $display("FAIL reset_be got=%h/%h exp=0/0", dmem_be, dmem_wdata); end
    rst_n = 1'b1;
    set_bubble();
    clk_step();
  endtask

  task automatic test_alu_op();
    set_ex(1'b1, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000);
    clk_step();
    checks++; if (mem_ALU_out !== 32'h1234) begin failures++; $display("FAIL alu_out got=%h exp=00001234", mem_ALU_out); end
    checks++; if (mem_rd !== 5'd5) begin failures++; $display("FAIL alu_rd got=%0d exp=5", mem_rd); end
    checks++; if (mem_valid !== 1'b1 || mem_RegWEn !== 1'b1) begin failures++; $display("FAIL alu_ctl got=%b%b exp=11", mem_valid, mem_RegWEn); end
    checks++; if (mem_pc4 !== 32'h1238 || mem_WBSel !== 2'd1) begin failures++; $display("FAIL alu_pc4 got=%h/%0d exp=00001238/1", mem_pc4, mem_WBSel); end
    checks++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin failures++; $display("FAIL alu_noreq got=%b%b exp=00", dmem_req, mem_stall); end
    set_bubble();
    clk_step();
  endtask

  task automatic test_store_byte();
    set_ex(1'b1, 32'h0000_0103, 32'h0000_00AB, 5'd0, 1'b0, 1'b1, 1'b1, 3'b000);
    dmem_ack = 1'b1;
    clk_step();
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || mem_stall !== 1'b1) begin failures++; $display("FAIL sb_req got=%b%b%b exp=111", dmem_req, dmem_we, mem_stall); end
    checks++; if (dmem_be !== 4'b1000) begin failures++; $display("FAIL sb_be got=%b exp=1000", dmem_be); end
    checks++; if (dmem_wdata !== 32'hABAB_ABAB) begin failures++; $display("FAIL sb_wdata got=%h exp=abababab", dmem_wdata); end
    checks++; if (dmem_addr !== 32'h0000_0100) begin failures++; $display("FAIL sb_addr got=%h exp=00000100", dmem_addr); end
    set_bubble();
    clk_step();
    dmem_ack = 1'b0;
    checks++; if (mem_stall !== 1'b0 || dmem_req !== 1'b0) begin failures++; $display("FAIL sb_done got=%b%b exp=00", mem_stall, dmem_req); end
    checks++; if (mem_ALU_out !== 32'h103 || mem_load_data !== 32'h0) begin failures++; $display("FAIL sb_hold got=%h/%h exp=00000103/0", mem_ALU_out, mem_load_data); end
    clk_step();
    checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL sb_advance got=%b exp=0", mem_valid); end
  endtask

  task automatic test_store_half();
    set_ex(1'b1, 32'h0000_0202, 32'h1234_5678, 5'd0, 1'b0, 1'b1, 1'b1, 3'b001);
    dmem_ack = 1'b1;
    clk_step();
    checks++; if (dmem_be !== 4'b1100 || dmem_wdata !== 32'h5678_5678) begin failures++; $display("FAIL sh_lanes got=%b/%h exp=1100/56785678", dmem_be, dmem_wdata); end
    set_bubble();
    clk_step();
    dmem_ack = 1'b0;
    clk_step();
  endtask

  task automatic test_load_sign();
    logic [2:0]  f3s  [2];
    logic [31:0] exps [2];
    int n;
    f3s[0] = 3'b000; exps[0] = 32'hFFFF_FF80;
    f3s[1] = 3'b100; exps[1] = 32'h0000_0080;
    dmem_rdata = 32'h0080_0000;
    for (int t = 0; t < 2; t++) begin
      dmem_ack = 1'b0;
      set_ex(1'b1, 32'h0000_0102, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, f3s[t]);
      n = 0;
      for (int i = 1; i <= 4; i++) begin
        clk_step();
        if (i == 1) set_bubble();
        if (mem_stall === 1'b1) n++;
        if (i == 4) dmem_ack = 1'b1;
      end
      clk_step();
      dmem_ack = 1'b0;
      checks++; if (n != 4 || mem_stall !== 1'b0) begin failures++; $display("FAIL load%0d_stall got=%0d/%b exp=4/0", t, n, mem_stall); end
      checks++; if (mem_load_data !== exps[t]) begin failures++; $display("FAIL load%0d_data got=%h exp=%h", t, mem_load_data, exps[t]); end
      checks++; if (mem_RegWEn !== 1'b1 || mem_rd !== 5'd7) begin failures++; $display("FAIL load%0d_wb got=%b/%0d exp=1/7", t, mem_RegWEn, mem_rd); end
      clk_step();
    end
  endtask

  task automatic test_fault();
    int reqs;
    reqs = 0;
    dmem_ack = 1'b0;
    set_ex(1'b1, 32'h0000_0102, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 3'b010);
    clk_step();
    if (dmem_req) reqs++;
    checks++; if (mem_fault !== 1'b1 || mem_RegWEn !== 1'b0 || mem_stall !== 1'b0) begin failures++; $display("FAIL lw_mis got=%b%b%b exp=100", mem_fault, mem_RegWEn, mem_stall); end
    set_ex(1'b1, 32'h0000_0100, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 3'b011);
    clk_step();
    if (dmem_req) reqs++;
    checks++; if (mem_fault !== 1'b1) begin failures++; $display("FAIL f3_illegal got=%b exp=1", mem_fault); end
    set_ex(1'b1, 32'h0000_0100, 32'h55, 5'd0, 1'b0, 1'b1, 1'b1, 3'b100);
    clk_step();
    if (dmem_req) reqs++;
    checks++; if (mem_fault !== 1'b1) begin failures++; $display("FAIL sbu_illegal got=%b exp=1", mem_fault); end
    set_bubble();
    clk_step();
    if (dmem_req) reqs++;
    checks++; if (mem_fault !== 1'b0) begin failures++; $display("FAIL fault_clear got=%b exp=0", mem_fault); end
    checks++; if (reqs != 0) begin failures++; $display("FAIL fault_noreq got=%0d exp=0", reqs); end
  endtask

  task automatic test_timeout();
    int n;
    dmem_ack = 1'b0;
    set_ex(1'b1, 32'h0000_0100, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 3'b010);
    clk_step();
    set_bubble();
    n = 0;
    while (mem_stall === 1'b1 && n < 40) begin
      n++;
      clk_step();
    end
    checks++; if (n != 16) begin failures++; $display("FAIL tmo_cycles got=%0d exp=16", n); end
    checks++; if (mem_bus_err !== 1'b1 || mem_stall !== 1'b0 || dmem_req !== 1'b0) begin failures++; $display("FAIL tmo_flags got=%b%b%b exp=100", mem_bus_err, mem_stall, dmem_req); end
    checks++; if (mem_RegWEn !== 1'b0) begin failures++; $display("FAIL tmo_regwen got=%b exp=0", mem_RegWEn); end
    clk_step();
    checks++; if (mem_bus_err !== 1'b0) begin failures++; $display("FAIL tmo_clear got=%b exp=0", mem_bus_err); end
  endtask

  task automatic test_reset_busy();
    dmem_ack = 1'b0;
    set_ex(1'b1, 32'h0000_0200, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 3'b010);
    clk_step();
    checks++; if (dmem_req !== 1'b1) begin failures++; $display("FAIL rb_busy got=%b exp=1", dmem_req); end
    rst_n = 1'b0;
    set_bubble();
    clk_step();
    checks++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin failures++; $display("FAIL rb_req got=%b%b exp=00", dmem_req, mem_stall); end
    checks++; if (mem_ALU_out !== 32'h0 || mem_valid !== 1'b0 || mem_RegWEn !== 1'b0) begin failures++; $display("FAIL rb_regs got=%h/%b%b exp=0/00", mem_ALU_out, mem_valid, mem_RegWEn); end
    rst_n = 1'b1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    clk_step();
    clk_step();
    dmem_ack = 1'b0;
    checks++; if (mem_load_data !== 32'h0 || dmem_req !== 1'b0 || mem_stall !== 1'b0) begin failures++; $display("FAIL rb_lateack got=%h/%b%b exp=0/00", mem_load_data, dmem_req, mem_stall); end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_store_byte();
    test_store_half();
    test_load_sign();
    test_fault();
    test_timeout();
    test_reset_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
